// File: rtl/postfix_eval_pkg.sv
// Shared types and constants for the postfix expression evaluator:
// FSM states, ASCII token codes and status codes written back to RAM.
package postfix_eval_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_CAP,
      S_EXEC,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_DONE
   } state_t;

   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_SUB = 8'h2D;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_EQ  = 8'h3D;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_UNDER   = 8'h01;
   localparam logic [7:0] ST_OVER    = 8'h02;
   localparam logic [7:0] ST_ILLEGAL = 8'h03;
   localparam logic [7:0] ST_DEPTH   = 8'h04;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_0) && (c <= CH_9);
   endfunction

   function automatic logic is_oper(input logic [7:0] c);
      return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL);
   endfunction

endpackage

// File: rtl/postfix_eval_stack.sv
// Operand LIFO for the evaluator. Entry 0 is always the top, so push shifts
// down and a binary operation collapses the top two entries into one.
module eval_stack #(
   parameter int DEPTH = 8,
   parameter int DW    = 16,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop2_push,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] top,
   output logic [DW-1:0] next,
   output logic [CW-1:0] depth,
   output logic          full,
   output logic          empty
);

   logic [CW-1:0] cnt_q;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [DW-1:0] ext   [DEPTH+2];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ext[i] = mem_q[i];
      ext[DEPTH]   = '0;
      ext[DEPTH+1] = '0;
      mem_d = mem_q;
      if (push) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      end else if (pop2_push) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) mem_d[i] = ext[i+1];
      end
   end

   // Only the occupancy count is reset; stale entries are never visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            cnt_q <= '0;
      else if (clr)       cnt_q <= '0;
      else if (push)      cnt_q <= cnt_q + CW'(1);
      else if (pop2_push) cnt_q <= cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign top   = mem_q[0];
   assign next  = mem_q[1];
   assign depth = cnt_q;
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/postfix_eval.sv
// Reads a postfix string from shared RAM, evaluates it on a LIFO and writes
// result high, result low and status back to RAM, then pulses FINISH.
module postfix_eval
   import postfix_eval_pkg::*;
#(
   parameter int SRC_BASE = 512,
   parameter int MAX_LEN  = 64,
   parameter int RES_ADRS = 768,
   parameter int DEPTH    = 8,
   parameter int DW       = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   output logic [9:0] ADRS,
   inout  wire  [7:0] DATA,
   output logic       R_WB,
   output logic       FINISH
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(MAX_LEN + 1);

   state_t        state_q;
   logic [PW-1:0] ptr_q;
   logic [7:0]    tok_q, status_q, wdata_q;
   logic [DW-1:0] res_q;
   logic [1:0]    wcnt_q;
   logic [9:0]    adrs_q;
   logic          rwb_q, finish_q, dcnt_q, armed_q;

   logic [DW-1:0] top, next, alu, din;
   logic [CW-1:0] depth;
   logic          full, empty, is_dig, is_op, is_eq, last;
   logic          st_push, st_pop2, st_clr, start_ok;
   logic [7:0]    exec_err, exec_st;
   logic [DW-1:0] exec_res;

   eval_stack #(.DEPTH(DEPTH), .DW(DW)) u_stack (
      .clk(CLK), .rst(RST), .clr(st_clr), .push(st_push), .pop2_push(st_pop2),
      .din(din), .top(top), .next(next), .depth(depth), .full(full), .empty(empty)
   );

   assign is_dig = is_digit(tok_q);
   assign is_op  = is_oper(tok_q);
   assign is_eq  = (tok_q == CH_EQ);
   assign last   = (ptr_q == PW'(MAX_LEN - 1));

   always_comb begin
      case (tok_q)
         CH_ADD:  alu = next + top;
         CH_SUB:  alu = next - top;
         default: alu = next * top;
      endcase
   end

   assign din = is_dig ? {{(DW-4){1'b0}}, tok_q[3:0]} : alu;

   always_comb begin
      exec_err = ST_OK;
      if (is_dig)     exec_err = full ? ST_OVER : ST_OK;
      else if (is_op) exec_err = (depth < CW'(2)) ? ST_UNDER : ST_OK;
      else if (is_eq) exec_err = (depth != CW'(1)) ? ST_DEPTH : ST_OK;
      else            exec_err = ST_ILLEGAL;
   end

   // Running out of bytes counts as illegal only if this byte did not end the scan.
   assign exec_st  = (exec_err != ST_OK) ? exec_err : ((!is_eq && last) ? ST_ILLEGAL : ST_OK);
   assign exec_res = (exec_st == ST_OK && is_eq) ? top : '0;

   assign start_ok = START && armed_q;
   assign st_clr   = (state_q == S_IDLE) && start_ok;
   assign st_push  = (state_q == S_EXEC) && is_dig && (exec_err == ST_OK);
   assign st_pop2  = (state_q == S_EXEC) && is_op && (exec_err == ST_OK);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         tok_q    <= '0;
         status_q <= ST_OK;
         wdata_q  <= '0;
         res_q    <= '0;
         wcnt_q   <= '0;
         adrs_q   <= '0;
         rwb_q    <= 1'b1;
         finish_q <= 1'b0;
         dcnt_q   <= 1'b0;
         armed_q  <= 1'b1;
      end else begin
         // START is a level; it must drop before another run can be accepted.
         if (!START) armed_q <= 1'b1;
         case (state_q)
            S_IDLE: if (start_ok) begin
               armed_q  <= 1'b0;
               ptr_q    <= '0;
               status_q <= ST_OK;
               res_q    <= '0;
               adrs_q   <= 10'(SRC_BASE);
               state_q  <= S_RD_ADDR;
            end
            S_RD_ADDR: state_q <= S_RD_CAP;
            S_RD_CAP: begin
               tok_q   <= DATA;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               ptr_q <= ptr_q + PW'(1);
               if (exec_st != ST_OK || is_eq || last) begin
                  status_q <= exec_st;
                  res_q    <= exec_res;
                  wdata_q  <= exec_res[DW-1:DW-8];
                  wcnt_q   <= '0;
                  adrs_q   <= 10'(RES_ADRS);
                  state_q  <= S_WR_SETUP;
               end else begin
                  adrs_q  <= 10'(SRC_BASE + int'(ptr_q) + 1);
                  state_q <= S_RD_ADDR;
               end
            end
            S_WR_SETUP: begin
               rwb_q   <= 1'b0;
               state_q <= S_WR_PULSE;
            end
            S_WR_PULSE: begin
               rwb_q   <= 1'b1;
               state_q <= S_WR_HOLD;
            end
            S_WR_HOLD: if (wcnt_q == 2'd2) begin
               finish_q <= 1'b1;
               dcnt_q   <= 1'b0;
               state_q  <= S_DONE;
            end else begin
               wcnt_q  <= wcnt_q + 2'd1;
               wdata_q <= (wcnt_q == 2'd0) ? res_q[7:0] : status_q;
               adrs_q  <= 10'(RES_ADRS) + {8'b0, wcnt_q} + 10'd1;
               state_q <= S_WR_SETUP;
            end
            S_DONE: if (dcnt_q) begin
               finish_q <= 1'b0;
               state_q  <= S_IDLE;
            end else begin
               dcnt_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ADRS   = adrs_q;
   assign R_WB   = rwb_q;
   assign FINISH = finish_q;
   assign DATA   = (state_q == S_WR_SETUP || state_q == S_WR_PULSE || state_q == S_WR_HOLD)
                   ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_postfix_eval.sv
// Bench for postfix_eval: RAM model on the shared bus, fixed vector table,
// reference evaluator for random strings, and reset/START-hold sequences.
module tb_postfix_eval;

   typedef logic [7:0] u8;

   typedef struct {
      string       s;
      logic [15:0] res;
      logic [7:0]  st;
      int          cyc;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST, START;
   logic [9:0] ADRS;
   wire  [7:0] DATA;
   logic       R_WB, FINISH;

   int errors = 0;
   int checks = 0;

   postfix_eval dut (
      .CLK(CLK), .RST(RST), .START(START), .ADRS(ADRS),
      .DATA(DATA), .R_WB(R_WB), .FINISH(FINISH)
   );

   always #5 CLK = ~CLK;

   u8  rom [1024];
   u8  wmem [3];
   int wr_total = 0;
   int stray    = 0;

   // RAM drives only while reading the source region.
   assign DATA = (R_WB === 1'b1 && ADRS >= 10'd512 && ADRS < 10'd768) ? rom[ADRS] : 8'hzz;

   always @(negedge CLK) begin
      if (R_WB === 1'b0) begin
         if (ADRS >= 10'd768 && ADRS <= 10'd770) begin
            wmem[2'(ADRS - 10'd768)] <= DATA;
            wr_total <= wr_total + 1;
         end else begin
            stray <= stray + 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic void model(input u8 q[$], output logic [15:0] r, output logic [7:0] st,
                                 output int n);
      int stk[$];
      int a, b;
      u8  c;
      bit done;
      r = 16'h0; st = 8'h00; n = 0; done = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         c = (i < q.size()) ? q[i] : 8'h00;
         n++;
         if (c >= 8'h30 && c <= 8'h39) begin
            if (stk.size() == 8) begin st = 8'h02; done = 1; end
            else stk.push_back(int'(c) - 48);
         end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A) begin
            if (stk.size() < 2) begin st = 8'h01; done = 1; end
            else begin
               b = stk.pop_back();
               a = stk.pop_back();
               if (c == 8'h2B)      stk.push_back((a + b) & 32'hFFFF);
               else if (c == 8'h2D) stk.push_back((a - b) & 32'hFFFF);
               else                 stk.push_back((a * b) & 32'hFFFF);
            end
         end else if (c == 8'h3D) begin
            if (stk.size() != 1) st = 8'h04;
            else r = 16'(stk[0]);
            done = 1;
         end else begin
            st = 8'h03; done = 1;
         end
      end
      if (!done) st = 8'h03;
   endfunction

   function automatic void str2q(input string s, output u8 q[$]);
      q = {};
      for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
   endfunction

   task automatic run(input u8 q[$], input bit hold, output logic [15:0] r, output logic [7:0] st,
                      output int cyc, output int fh, output int nw, output int ns);
      int w0, s0, extra;
      w0 = wr_total; s0 = stray;
      for (int i = 0; i < 64; i++) rom[512 + i] = (i < q.size()) ? q[i] : 8'h00;
      rom[576] = 8'h3D;
      @(negedge CLK) START = 1'b1;
      @(posedge CLK);
      @(negedge CLK) if (!hold) START = 1'b0;
      cyc = 0; fh = 0;
      while (cyc < 400) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (FINISH) fh++;
         else if (fh > 0) break;
      end
      @(negedge CLK);
      r  = {wmem[0], wmem[1]};
      st = wmem[2];
      nw = wr_total - w0;
      ns = stray - s0;
      if (hold) begin
         extra = 0;
         repeat (40) begin
            @(negedge CLK);
            if (FINISH || !R_WB || ADRS != 10'd770) extra++;
         end
         chk("no_rerun_while_start_held", extra, 0);
         START = 1'b0;
      end
   endtask

   task automatic check_run(input string name, input u8 q[$], input logic [15:0] er,
                            input logic [7:0] est, input int ecyc, input bit hold);
      logic [15:0] r;
      logic [7:0]  st;
      int cyc, fh, nw, ns;
      run(q, hold, r, st, cyc, fh, nw, ns);
      chk({name, " result"}, int'(r), int'(er));
      chk({name, " status"}, int'(st), int'(est));
      chk({name, " cycles"}, cyc, ecyc);
      chk({name, " finish_len"}, fh, 2);
      chk({name, " writes"}, nw * 100 + ns, 300);
   endtask

   vec_t        tbl[$];
   u8           q[$];
   logic [15:0] mr;
   logic [7:0]  mst;
   int          mn, w0, guard;

   initial begin
      RST = 1'b1; START = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      repeat (3) @(negedge CLK);
      chk("reset ADRS", int'(ADRS), 0);
      chk("reset R_WB", int'(R_WB), 1);
      chk("reset DATA_z", int'(DATA === 8'hzz), 1);
      chk("reset FINISH", int'(FINISH), 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      tbl.push_back('{"34+2*=",       16'h000E, 8'h00, 29});
      tbl.push_back('{"12-=",         16'hFFFF, 8'h00, 23});
      tbl.push_back('{"99*9*9*9*9*=", 16'h1BF1, 8'h00, 47});
      tbl.push_back('{"+=",           16'h0000, 8'h01, 14});
      tbl.push_back('{"123456789=",   16'h0000, 8'h02, 38});
      tbl.push_back('{"3A=",          16'h0000, 8'h03, 17});
      tbl.push_back('{"12=",          16'h0000, 8'h04, 20});
      tbl.push_back('{"7=",           16'h0007, 8'h00, 17});
      for (int k = 0; k < tbl.size(); k++) begin
         str2q(tbl[k].s, q);
         check_run(tbl[k].s, q, tbl[k].res, tbl[k].st, tbl[k].cyc, 1'b0);
      end

      // 64 legal bytes with no terminator; byte 65 is '=' and must not be read.
      q = {8'h31};
      for (int i = 0; i < 31; i++) begin q.push_back(8'h31); q.push_back(8'h2B); end
      q.push_back(8'h31);
      check_run("max_len", q, 16'h0000, 8'h03, 203, 1'b0);

      for (int t = 0; t < 25; t++) begin
         q = {};
         for (int i = 0; i < $urandom_range(1, 12); i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: q.push_back(u8'(8'h30 + $urandom_range(0, 9)));
               5:             q.push_back(8'h2B);
               6:             q.push_back(8'h2D);
               7:             q.push_back(8'h2A);
               8:             q.push_back(8'h3D);
               default:       q.push_back(u8'($urandom_range(0, 255)));
            endcase
         end
         q.push_back(8'h3D);
         model(q, mr, mst, mn);
         check_run($sformatf("rand%0d", t), q, mr, mst, 3 * mn + 11, 1'b0);
      end

      // Reset during the second write, then a clean run with START held through DONE.
      str2q("34+2*=", q);
      for (int i = 0; i < 64; i++) rom[512 + i] = (i < q.size()) ? q[i] : 8'h00;
      w0 = wr_total;
      @(negedge CLK) START = 1'b1;
      @(negedge CLK) START = 1'b0;
      guard = 0;
      while (wr_total - w0 < 2 && guard < 200) begin @(negedge CLK); guard++; end
      chk("reach_second_write", int'(guard < 200), 1);
      #1 RST = 1'b1;
      #1;
      chk("midrst R_WB", int'(R_WB), 1);
      chk("midrst DATA_z", int'(DATA === 8'hzz), 1);
      chk("midrst ADRS", int'(ADRS), 0);
      chk("midrst FINISH", int'(FINISH), 0);
      @(negedge CLK);
      chk("midrst R_WB held", int'(R_WB), 1);
      RST = 1'b0;
      @(negedge CLK);
      str2q("34+2*=", q);
      check_run("after_reset", q, 16'h000E, 8'h00, 29, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
